period_step_ctrl: RTL and testbench

//  Sequencer for the 24-bit tone-period register (doubling/halving datapath). Turns user keys
//  and an optional auto-sweep into one-cycle increase/decrease step pulses for that register.

---
 rtl/period_step_ctrl_if.sv | 27 ++
 rtl/period_step_ctrl.sv | 139 +++++++++++++
 tb/tb_period_step_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/period_step_ctrl_if.sv
// Key/limit inputs and step-pulse outputs of the tone-period step sequencer.
interface period_step_ctrl_if #(
  parameter int unsigned WIDTH = 24
);
  logic             key_up;
  logic             key_dn;
  logic             sweep_en;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] min;
  logic             increase;
  logic             decrease;
  logic             sweeping;
  logic             sweep_dir;

  // Key conditioning and the period register side
  modport master (
    output key_up, key_dn, sweep_en, period, max, min,
    input  increase, decrease, sweeping, sweep_dir
  );

  // Sequencer side
  modport slave (
    input  key_up, key_dn, sweep_en, period, max, min,
    output increase, decrease, sweeping, sweep_dir
  );
endinterface

// File: rtl/period_step_ctrl.sv
// Step sequencer for the doubling/halving tone-period register: turns key presses,
// key auto-repeat and a ping-pong sweep into limit-checked one-cycle step pulses.
module period_step_ctrl #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned HOLD_CYC   = 25_000_000,
  parameter int unsigned REPEAT_CYC = 5_000_000,
  parameter int unsigned SWEEP_CYC  = 12_500_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic              clk,
  input  logic              reset,
  period_step_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] SWEEP_LAST  = CNT_W'(SWEEP_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, SWEEP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             rep_q, rep_d;
  logic             dir_q, dir_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             key_up_q, key_dn_q;
  logic             sweeping_q;

  logic [WIDTH:0]   period_x2_c;
  logic             can_up_c, can_dn_c;
  logic             edge_up_c, edge_dn_c;
  logic             last_c;

  // Limit checks at full width so the doubled period cannot wrap
  assign period_x2_c = {bus.period, 1'b0};
  assign can_up_c    = period_x2_c <= {1'b0, bus.max};
  assign can_dn_c    = (bus.period >> 1) >= bus.min;

  // A key start is a rising edge with the other key released
  assign edge_up_c = bus.key_up & ~key_up_q & ~bus.key_dn;
  assign edge_dn_c = bus.key_dn & ~key_dn_q & ~bus.key_up;
  assign last_c    = (timer_q == (rep_q ? REPEAT_LAST : HOLD_LAST));

  // Next-state, timer and step-pulse decisions
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rep_d   = rep_q;
    dir_d   = dir_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    unique case (state_q)
      IDLE, SWEEP: begin
        if (edge_up_c) begin
          state_d = HOLD_UP;
          timer_d = '0;
          rep_d   = 1'b0;
          inc_d   = can_up_c;
        end else if (edge_dn_c) begin
          state_d = HOLD_DN;
          timer_d = '0;
          rep_d   = 1'b0;
          dec_d   = can_dn_c;
        end else if (state_q == IDLE) begin
          if (bus.sweep_en) begin
            state_d = SWEEP;
            timer_d = '0;
          end
        end else if (!bus.sweep_en) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == SWEEP_LAST) begin
          timer_d = '0;
          if (dir_q && can_up_c) begin
            inc_d = 1'b1;
          end else if (!dir_q && can_dn_c) begin
            dec_d = 1'b1;
          end else begin
            dir_d = ~dir_q;
            inc_d = ~dir_q & can_up_c;
            dec_d = dir_q & can_dn_c;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      HOLD_UP, HOLD_DN: begin
        if ((state_q == HOLD_UP) ? (!bus.key_up || bus.key_dn)
                                 : (!bus.key_dn || bus.key_up)) begin
          timer_d = '0;
          state_d = bus.sweep_en ? SWEEP : IDLE;
        end else if (last_c) begin
          timer_d = '0;
          rep_d   = 1'b1;
          inc_d   = (state_q == HOLD_UP) & can_up_c;
          dec_d   = (state_q == HOLD_DN) & can_dn_c;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State, timer, key history and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rep_q      <= 1'b0;
      dir_q      <= 1'b1;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      key_up_q   <= 1'b0;
      key_dn_q   <= 1'b0;
      sweeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rep_q      <= rep_d;
      dir_q      <= dir_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      key_up_q   <= bus.key_up;
      key_dn_q   <= bus.key_dn;
      sweeping_q <= (state_d == SWEEP);
    end
  end

  assign bus.increase  = inc_q;
  assign bus.decrease  = dec_q;
  assign bus.sweeping  = sweeping_q;
  assign bus.sweep_dir = dir_q;

endmodule

// File: tb/tb_period_step_ctrl.sv
// Bench for period_step_ctrl with an attached doubling/halving period register and a
// cycle-level behavioural reference built from key ages and sweep ages.
module tb_period_step_ctrl;

  localparam int unsigned W = 24;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int SWC  = 3;
  localparam int M_IDLE = 0, M_HUP = 1, M_HDN = 2, M_SWEEP = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  period_step_ctrl_if #(.WIDTH(W)) bus();

  period_step_ctrl #(
    .WIDTH(W), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .SWEEP_CYC(SWC), .CNT_W(26)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Period register that the pulses act on
  logic [W-1:0] p_reg;
  logic         load_req = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] lim_max  = W'(64);
  logic [W-1:0] lim_min  = W'(2);

  always @(posedge clk) begin
    if (load_req)          p_reg <= load_val;
    else if (bus.increase) p_reg <= p_reg << 1;
    else if (bus.decrease) p_reg <= p_reg >> 1;
  end

  assign bus.period = p_reg;
  assign bus.max    = lim_max;
  assign bus.min    = lim_min;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  int           m_mode, m_age;
  bit           m_dir, m_hu, m_hd, m_inc, m_dec;
  logic [W-1:0] m_period;

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_dir = 1'b1;
    m_hu = 1'b0; m_hd = 1'b0; m_inc = 1'b0; m_dec = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] next_p;
    bit ku, kd, se, vu, vd, cu, cd, ni, nd, held;
    next_p = m_period;
    if (load_req)   next_p = load_val;
    else if (m_inc) next_p = m_period << 1;
    else if (m_dec) next_p = m_period >> 1;
    ku = bus.key_up; kd = bus.key_dn; se = bus.sweep_en;
    cu = (longint'(m_period) * 2) <= longint'(lim_max);
    cd = (m_period / 2) >= lim_min;
    vu = ku && !m_hu && !kd;
    vd = kd && !m_hd && !ku;
    ni = 1'b0; nd = 1'b0;
    if (!reset) begin
      model_reset();
    end else begin
      if ((m_mode == M_IDLE || m_mode == M_SWEEP) && (vu || vd)) begin
        m_mode = vu ? M_HUP : M_HDN;
        m_age  = 0;
        ni = vu && cu;
        nd = vd && cd;
      end else if (m_mode == M_IDLE) begin
        if (se) begin m_mode = M_SWEEP; m_age = 0; end
      end else if (m_mode == M_SWEEP) begin
        if (!se) begin
          m_mode = M_IDLE;
        end else begin
          m_age++;
          if (m_age % SWC == 0) begin
            if (!(m_dir ? cu : cd)) m_dir = !m_dir;
            ni = m_dir && cu;
            nd = !m_dir && cd;
          end
        end
      end else begin
        held = (m_mode == M_HUP) ? (ku && !kd) : (kd && !ku);
        if (!held) begin
          m_mode = se ? M_SWEEP : M_IDLE;
          m_age  = 0;
        end else begin
          m_age++;
          if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0)) begin
            ni = (m_mode == M_HUP) && cu;
            nd = (m_mode == M_HDN) && cd;
          end
        end
      end
      m_hu = ku; m_hd = kd; m_inc = ni; m_dec = nd;
    end
    m_period = next_p;
  endtask

  // One clock: DUT and model both consume the inputs present at the edge
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    load_req = 1'b0;
  endtask

  task automatic load_period(input logic [W-1:0] v);
    load_req = 1'b1;
    load_val = v;
    tick();
  endtask

  function automatic logic [W+3:0] obs();
    return {bus.increase, bus.decrease, bus.sweeping, bus.sweep_dir, p_reg};
  endfunction

  function automatic logic [W+3:0] expv();
    return {m_inc, m_dec, (m_mode == M_SWEEP), m_dir, m_period};
  endfunction

  task automatic test_reset();
    bus.key_up = 1'b0; bus.key_dn = 1'b0; bus.sweep_en = 1'b0;
    model_reset();
    m_period = '0;
    load_period(W'(8));
    n_tests++;
    if ({bus.increase, bus.decrease, bus.sweeping, bus.sweep_dir, p_reg} !== {4'b0001, W'(8)}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs(), {4'b0001, W'(8)});
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL reset_release cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_tap();
    int n_inc = 0, n_dec = 0;
    load_period(W'(8));
    bus.key_up = 1'b1;
    tick();
    n_tests++;
    if (bus.increase !== 1'b1) begin
      n_fail++; $display("FAIL tap_latency: got inc=%b want 1", bus.increase);
    end
    n_inc += int'(bus.increase);
    bus.key_up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_inc += int'(bus.increase); n_dec += int'(bus.decrease);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL tap cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (n_inc != 1 || n_dec != 0 || p_reg !== W'(16)) begin
      n_fail++; $display("FAIL tap_result: got inc=%0d dec=%0d period=%0d want 1 0 16", n_inc, n_dec, p_reg);
    end
  endtask

  task automatic test_hold_repeat();
    int got[$];
    int want[5] = '{1, 9, 13, 17, 21};
    load_period(W'(2));
    bus.key_up = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.increase) got.push_back(i);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL hold cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    bus.key_up = 1'b0;
    tick();
    n_tests++;
    if (got.size() != 5) begin
      n_fail++; $display("FAIL hold_count: got %0d pulses want 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (got[k] != want[k]) begin
          n_fail++; $display("FAIL hold_timing %0d: got cycle %0d want %0d", k, got[k], want[k]);
        end
      end
    end
    n_tests++;
    if (p_reg !== W'(64)) begin
      n_fail++; $display("FAIL hold_period: got %0d want 64", p_reg);
    end
  endtask

  task automatic test_limits();
    int n_inc = 0, n_dec = 0;
    load_period(W'(64));
    bus.key_up = 1'b1; tick(); n_inc += int'(bus.increase);
    bus.key_up = 1'b0; tick(); n_inc += int'(bus.increase);
    load_period(W'(2));
    bus.key_dn = 1'b1; tick(); n_dec += int'(bus.decrease);
    bus.key_dn = 1'b0; tick(); n_dec += int'(bus.decrease);
    n_tests++;
    if (n_inc != 0 || n_dec != 0 || p_reg !== W'(2)) begin
      n_fail++; $display("FAIL limits: got inc=%0d dec=%0d period=%0d want 0 0 2", n_inc, n_dec, p_reg);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] prev;
    logic [W-1:0] seq[$];
    int want[8] = '{32, 64, 32, 16, 8, 4, 2, 4};
    bus.sweep_en = 1'b1;
    load_period(W'(16));
    prev = p_reg;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (p_reg !== prev) begin seq.push_back(p_reg); prev = p_reg; end
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL sweep cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (seq.size() < 8) begin
      n_fail++; $display("FAIL sweep_count: got %0d changes want 8", seq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (seq[k] !== W'(want[k])) begin
          n_fail++; $display("FAIL sweep_seq %0d: got %0d want %0d", k, seq[k], want[k]);
        end
      end
    end
    bus.sweep_en = 1'b0;
    tick();
    n_tests++;
    if (bus.sweeping !== 1'b0 || bus.sweep_dir !== 1'b1) begin
      n_fail++; $display("FAIL sweep_stop: got sweeping=%b dir=%b want 0 1", bus.sweeping, bus.sweep_dir);
    end
  endtask

  task automatic test_both_keys();
    int n_p = 0;
    load_period(W'(8));
    bus.key_up = 1'b1; bus.key_dn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_p += int'(bus.increase) + int'(bus.decrease);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL both cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (n_p != 0 || bus.sweeping !== 1'b0 || p_reg !== W'(8)) begin
      n_fail++; $display("FAIL both_keys: got pulses=%0d sweeping=%b period=%0d want 0 0 8", n_p, bus.sweeping, p_reg);
    end
    bus.key_up = 1'b0; bus.key_dn = 1'b0;
    tick();
  endtask

  task automatic test_wide_boundary();
    int n_a = 0, n_b = 0;
    lim_max = '1;
    load_period(W'(24'h800000));
    bus.key_up = 1'b1; tick(); n_a += int'(bus.increase);
    bus.key_up = 1'b0; tick(); n_a += int'(bus.increase);
    load_period(W'(24'h400000));
    bus.key_up = 1'b1; tick(); n_b += int'(bus.increase);
    bus.key_up = 1'b0; tick(); n_b += int'(bus.increase);
    n_tests++;
    if (n_a != 0 || n_b != 1 || p_reg !== W'(24'h800000)) begin
      n_fail++; $display("FAIL wide_limit: got blocked=%0d allowed=%0d period=%h want 0 1 800000", n_a, n_b, p_reg);
    end
    lim_max = W'(64);
    load_period(W'(8));
  endtask

  task automatic test_async_reset();
    bus.sweep_en = 1'b1;
    load_period(W'(64));
    for (int i = 0; i < 3; i++) tick();
    bus.sweep_en = 1'b0;
    tick();
    bus.key_up = 1'b1;
    tick();
    n_tests++;
    if (bus.increase !== 1'b1 || bus.sweep_dir !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset: got inc=%b dir=%b want 1 0", bus.increase, bus.sweep_dir);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({bus.increase, bus.decrease, bus.sweeping, bus.sweep_dir} !== 4'b0001) begin
      n_fail++; $display("FAIL async_reset: got %b want 0001", {bus.increase, bus.decrease, bus.sweeping, bus.sweep_dir});
    end
    bus.key_up = 1'b0;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL post_reset cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (p_reg !== W'(32) || bus.sweep_dir !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_state: got period=%0d dir=%b want 32 1", p_reg, bus.sweep_dir);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) bus.key_up = ~bus.key_up;
      if ($urandom_range(0, 11) == 0) bus.key_dn = ~bus.key_dn;
      if ($urandom_range(0, 39) == 0) bus.sweep_en = ~bus.sweep_en;
      if ($urandom_range(0, 49) == 0) begin
        load_req = 1'b1;
        load_val = W'(1) << $urandom_range(0, 7);
      end
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    bus.key_up = 1'b0; bus.key_dn = 1'b0; bus.sweep_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_repeat();
    test_limits();
    test_sweep();
    test_both_keys();
    test_wide_boundary();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
